// File: rtl/weight_stream_sram.sv
// Single-port weight SRAM with a flow-controlled burst-read streamer (IDLE/RUN FSM).
// Define WSRAM_WRAP_EN to let bursts wrap from DEPTH-1 to 0; otherwise overrunning bursts are rejected.
module weight_stream_sram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2000,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] q,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] ONE_A = 1;
`ifdef WSRAM_WRAP_EN
    localparam logic [ADDR_W:0] LAST_X  = DEPTH_X - 1'b1;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] left_q, left_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_last_q, rd_last_d;
    logic              ov_q, ov_d;
    logic              ol_q, ol_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              sk_v_q, sk_v_d;
    logic              sk_last_q, sk_last_d;
    logic [DATA_W-1:0] sk_data_q, sk_data_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q;

    logic              mem_we, rd_en, pop, waddr_ok, base_ok;
    logic [1:0]        occ;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W:0]   base_x, len_x;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr[IDX_W-1:0]] <= wdata;
        if (rd_en)  rd_data_q <= mem[rd_addr_q[IDX_W-1:0]];
    end

    assign base_x   = {1'b0, base_addr};
    assign len_x    = {1'b0, len};
    assign waddr_ok = {1'b0, waddr} < DEPTH_X;

`ifdef WSRAM_WRAP_EN
    assign next_addr = ({1'b0, rd_addr_q} == LAST_X) ? '0 : rd_addr_q + ONE_A;
    assign base_ok   = base_x < DEPTH_X;
`else
    assign next_addr = rd_addr_q + ONE_A;
    assign base_ok   = (base_x < DEPTH_X) && ((base_x + len_x) <= DEPTH_X);
`endif

    // Words still held after this edge's transfer plus the read in flight; a new read keeps it <= 2.
    assign pop = ov_q && out_ready;
    assign occ = {1'b0, ov_q & ~out_ready} + {1'b0, sk_v_q} + {1'b0, rd_pend_q};

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        left_d    = left_q;
        rd_pend_d = 1'b0;
        rd_last_d = 1'b0;
        ov_d      = ov_q;
        ol_d      = ol_q;
        q_d       = q_q;
        sk_v_d    = sk_v_q;
        sk_last_d = sk_last_q;
        sk_data_d = sk_data_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        rd_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (we) begin
                    if (waddr_ok) mem_we = 1'b1;
                    else          err_d  = 1'b1;
                end else if (start && (len != '0)) begin
                    if (!base_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        rd_addr_d = base_addr;
                        left_d    = len;
                    end
                end
            end
            RUN: begin
                if (we) err_d = 1'b1;
                if ((left_q != '0) && (occ < 2'd2)) begin
                    rd_en     = 1'b1;
                    rd_pend_d = 1'b1;
                    rd_last_d = (left_q == ONE_A);
                    left_d    = left_q - ONE_A;
                    rd_addr_d = next_addr;
                end
                // Head refills from the skid slot first so ordering is preserved.
                if (!ov_q || pop) begin
                    if (sk_v_q) begin
                        ov_d      = 1'b1;
                        q_d       = sk_data_q;
                        ol_d      = sk_last_q;
                        sk_v_d    = rd_pend_q;
                        sk_data_d = rd_data_q;
                        sk_last_d = rd_last_q;
                    end else if (rd_pend_q) begin
                        ov_d = 1'b1;
                        q_d  = rd_data_q;
                        ol_d = rd_last_q;
                    end else begin
                        ov_d = 1'b0;
                        ol_d = 1'b0;
                    end
                end else if (rd_pend_q) begin
                    sk_v_d    = 1'b1;
                    sk_data_d = rd_data_q;
                    sk_last_d = rd_last_q;
                end
                if (pop && ol_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            left_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
            ov_q      <= 1'b0;
            ol_q      <= 1'b0;
            q_q       <= '0;
            sk_v_q    <= 1'b0;
            sk_last_q <= 1'b0;
            sk_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            left_q    <= left_d;
            rd_pend_q <= rd_pend_d;
            rd_last_q <= rd_last_d;
            ov_q      <= ov_d;
            ol_q      <= ol_d;
            q_q       <= q_d;
            sk_v_q    <= sk_v_d;
            sk_last_q <= sk_last_d;
            sk_data_q <= sk_data_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign q         = q_q;
    assign out_last  = ol_q;
    assign busy      = (state_q == RUN);
    assign err       = err_q;

endmodule

// File: tb/tb_weight_stream_sram.sv
// Randomized self-checking bench for weight_stream_sram against an array/queue reference model.
// Honours WSRAM_WRAP_EN to match the wrap or reject build of the design.
module tb_weight_stream_sram;
    localparam int DW    = 16;
    localparam int DEPTH = 2000;
    localparam int AW    = 12;
`ifdef WSRAM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, we, start, out_ready;
    logic          out_valid, out_last, busy, err;
    logic [AW-1:0] waddr, base_addr, len;
    logic [DW-1:0] wdata, q;

    logic [DW-1:0] model [DEPTH];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    weight_stream_sram #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .q         (q),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input bit chk);
        we    = 1'b1;
        waddr = AW'(a);
        wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
        if (a < DEPTH) model[a] = d;
        if (chk) begin
            check("wr_err", err, a >= DEPTH);
            if (a >= DEPTH) begin
                @(posedge clk); #1;
                check("wr_err_pulse", err, 0);
            end
        end
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1,0,1..., 2: random ready
    task automatic burst(input int b, input int n, input int mode, input bit inj);
        logic [DW-1:0] exp_q[$];
        logic [DW:0]   prev;
        logic [5:0]    pat;
        int cyc, got, first, k, bubbles;
        bit rdy, rej, prev_stall;
        pat = 6'b101001;
        rej = (n != 0) && ((b >= DEPTH) || (!WRAP && (b + n > DEPTH)));
        for (int i = 0; i < n; i++) exp_q.push_back(model[(b + i) % DEPTH]);
        start     = 1'b1;
        base_addr = AW'(b);
        len       = AW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0 || rej) begin
            check("req_busy", busy, 0);
            check("req_err", err, rej);
            @(posedge clk); #1;
            check("req_idle", {busy, out_valid, err}, 0);
            return;
        end
        check("busy_rise", busy, 1);
        cyc = 0; got = 0; first = -1; k = 0; bubbles = 0;
        prev_stall = 1'b0; prev = '0;
        while (got < n && cyc < 200) begin
            if (inj && cyc == 2) begin
                check("run_we_err", err, 1);
                we = 1'b0;
            end
            if (prev_stall) check("stall_hold", {out_valid, out_last, q}, {1'b1, prev});
            if (out_valid && first < 0) first = cyc;
            if (mode == 0 && first >= 0 && !out_valid) bubbles++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[k % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (first >= 0) k++;
            out_ready = rdy;
            if (out_valid && rdy) begin
                check("word", q, exp_q[got]);
                check("last", out_last, got == n - 1);
                got++;
            end
            prev_stall = out_valid && !rdy;
            prev       = {out_last, q};
            if (inj && cyc == 1) begin
                we    = 1'b1;
                waddr = AW'(b);
                wdata = ~model[b];
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        we        = 1'b0;
        check("burst_done", got, n);
        check("first_lat", first, 2);
        if (mode == 0) check("bubbles", bubbles, 0);
        check("busy_fall", {busy, out_valid}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        rst_n = 1'b0; we = 1'b0; start = 1'b0; out_ready = 1'b0;
        waddr = '0; wdata = '0; base_addr = '0; len = '0;
        #2;
        check("rst_state", {busy, out_valid, out_last, err, q}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) wr(i, DW'($urandom), 1'b0);

        for (int i = 0; i < 4; i++) wr(10 + i, DW'(16'h1111 + i), 1'b1);
        burst(10, 4, 0, 1'b0);
        burst(10, 4, 1, 1'b0);

        we = 1'b1; waddr = AW'(5); wdata = 16'hABCD;
        start = 1'b1; base_addr = AW'(10); len = AW'(4);
        @(posedge clk); #1;
        we = 1'b0; start = 1'b0;
        model[5] = 16'hABCD;
        check("we_start_busy", busy, 0);
        check("we_start_err", err, 0);
        burst(5, 1, 0, 1'b0);
        burst(10, 0, 0, 1'b0);

        burst(1998, 4, 0, 1'b0);

        start = 1'b1; base_addr = AW'(10); len = AW'(8); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (out_valid) got++;
            @(posedge clk); #1;
        end
        check("pre_rst_words", got, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {busy, out_valid, out_last, err, q}, 0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst(10, 1, 0, 1'b0);

        burst(10, 4, 0, 1'b1);
        wr(2000, 16'hDEAD, 1'b1);
        burst(8, 6, 0, 1'b0);
        burst(1990, 10, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int b, n;
            if ($urandom_range(0, 3) == 0) begin
                wr(int'($urandom_range(0, 2100)), DW'($urandom), 1'b1);
            end else begin
                b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1990, 2010))
                                                : int'($urandom_range(0, DEPTH - 1));
                n = int'($urandom_range(0, 9));
                burst(b, n, 2, 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
